// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS32 datapath and controller.
// Handles R-type add/sub/and/or/slt, lw, sw, beq, addi and j. There is no
// instruction or data memory in here; both sit outside on combinational ports.
// Handshake note: there is no valid/ready handshake. Each cycle the core
// consumes `instr` and `readdata` combinationally and commits on the rising edge.
module mips_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic        memwrite,
    output logic [31:0] aluout,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [31:0] rs_val, rt_val, src_b;
    logic [31:0] pc_plus4, br_target, j_target;

    logic        reg_we;
    logic [4:0]  wr_addr;
    logic        wr_from_mem;
    logic        use_imm;
    logic        is_beq;
    logic        is_j;
    alu_op_e     alu_op;
    logic [31:0] wr_data;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    // $0 is forced to read zero regardless of storage contents.
    assign rs_val    = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    assign writedata = rt_val;
    assign pc        = pc_q;

    // Decode opcode/funct into register-write, memory and ALU controls.
    always_comb begin
        reg_we      = 1'b0;
        wr_addr     = rt;
        wr_from_mem = 1'b0;
        use_imm     = 1'b0;
        is_beq      = 1'b0;
        is_j        = 1'b0;
        memwrite    = 1'b0;
        alu_op      = ALU_ZERO;
        case (opcode)
            OP_RTYPE: begin
                wr_addr = rd;
                reg_we  = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_we = 1'b0;
                endcase
            end
            OP_LW: begin
                reg_we      = 1'b1;
                wr_from_mem = 1'b1;
                use_imm     = 1'b1;
                alu_op      = ALU_ADD;
            end
            OP_SW: begin
                memwrite = 1'b1;
                use_imm  = 1'b1;
                alu_op   = ALU_ADD;
            end
            OP_BEQ: begin
                is_beq = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                use_imm = 1'b1;
                alu_op  = ALU_ADD;
            end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    // ALU: 32-bit wrapping arithmetic, signed compare for slt.
    always_comb begin
        src_b  = use_imm ? imm_ext : rt_val;
        aluout = 32'd0;
        case (alu_op)
            ALU_ADD: aluout = rs_val + src_b;
            ALU_SUB: aluout = rs_val - src_b;
            ALU_AND: aluout = rs_val & src_b;
            ALU_OR:  aluout = rs_val | src_b;
            ALU_SLT: aluout = {31'd0, ($signed(rs_val) < $signed(src_b))};
            default: aluout = 32'd0;
        endcase
    end

    // Next-PC selection: sequential, taken branch, or jump.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
        j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        wr_data   = wr_from_mem ? readdata : aluout;
        pc_d      = pc_plus4;
        if (is_j) begin
            pc_d = j_target;
        end else if (is_beq && (aluout == 32'd0)) begin
            pc_d = br_target;
        end
    end

    // PC and register file update; reset clears every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q <= pc_d;
            if (reg_we && (wr_addr != 5'd0)) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: directed instruction stream with hand-computed expectations.
// The driver applies one instruction per cycle just after the rising edge and
// pushes the expected outputs; the monitor pops and compares on the falling edge.
module tb_mips_core;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        chk_alu;
    logic [31:0] wd;
    logic        chk_wd;
    logic        mw;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors;
  int   checks;
  int   vec_id;
  bit   drive_done;

  mips_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .pc       (pc),
    .memwrite (memwrite),
    .aluout   (aluout),
    .writedata(writedata),
    .readdata (readdata)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst      = 1'b0;
    instr    = 32'd0;
    readdata = 32'd0;
  end

  // driver: present one instruction for the coming cycle and queue its expectation
  task automatic issue(input logic [31:0] ins, input logic [31:0] e_pc,
                       input logic [31:0] e_alu, input logic c_alu,
                       input logic [31:0] e_wd, input logic c_wd,
                       input logic e_mw, input logic [31:0] rdata);
    exp_t e;
    @(posedge clk);
    #1;
    instr    = ins;
    readdata = rdata;
    e.id      = vec_id[7:0];
    e.pc      = e_pc;
    e.alu     = e_alu;
    e.chk_alu = c_alu;
    e.wd      = e_wd;
    e.chk_wd  = c_wd;
    e.mw      = e_mw;
    exp_q.push_back(e);
    vec_id++;
  endtask

  task automatic cmp32(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      cmp32("pc", int'(mon_e.id), pc, mon_e.pc);
      cmp32("memwrite", int'(mon_e.id), {31'd0, memwrite}, {31'd0, mon_e.mw});
      if (mon_e.chk_alu) cmp32("aluout", int'(mon_e.id), aluout, mon_e.alu);
      if (mon_e.chk_wd)  cmp32("writedata", int'(mon_e.id), writedata, mon_e.wd);
    end
  end

  // stimulus
  initial begin
    logic [31:0] ins;
    int wait_cyc;
    errors     = 0;
    checks     = 0;
    vec_id     = 0;
    drive_done = 1'b0;

    // reset held: every register reads 0 through add $0,$r,$(31-r); pc stays 0
    for (int r = 1; r < 32; r++) begin
      ins = (32'(r) << 21) | (32'(31 - r) << 16) | 32'h20;
      issue(ins, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    // sw decodes during reset: memwrite follows instr
    issue(32'hac070004, 32'h0, 32'h4, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0);

    // release reset, nops advance pc
    @(posedge clk);
    #1;
    rst   = 1'b1;
    instr = 32'd0;
    begin
      exp_t e;
      e = '{id: vec_id[7:0], pc: 32'h0, alu: 32'h0, chk_alu: 1'b1, wd: 32'h0, chk_wd: 1'b0, mw: 1'b0};
      exp_q.push_back(e);
      vec_id++;
    end
    issue(32'h00000000, 32'd4,  32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h00000000, 32'd8,  32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

    // addi sequence
    issue(32'h20020005, 32'd12, 32'd5,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h2003000c, 32'd16, 32'd12, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h2067fff7, 32'd20, 32'd3,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    // or / and / add
    issue(32'h00e22025, 32'd24, 32'd7,  1'b1, 32'd5, 1'b1, 1'b0, 32'h0);
    issue(32'h00642824, 32'd28, 32'd4,  1'b1, 32'd7, 1'b1, 1'b0, 32'h0);
    issue(32'h00a42820, 32'd32, 32'd11, 1'b1, 32'd7, 1'b1, 1'b0, 32'h0);
    // beq not taken: 11 - 3 = 8
    issue(32'h10a7000a, 32'd36, 32'd8,  1'b1, 32'd3, 1'b1, 1'b0, 32'h0);
    // beq taken: next pc = 44 + 40 = 84
    issue(32'h10e7000a, 32'd40, 32'd0,  1'b1, 32'd3, 1'b1, 1'b0, 32'h0);
    // j 0x10 -> 0x40
    issue(32'h08000010, 32'd84, 32'd0,  1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // sw $7,4($0)
    issue(32'hac070004, 32'h40, 32'd4,  1'b1, 32'd3, 1'b1, 1'b1, 32'h0);
    // lw $8,0($0) with deadbeef on the bus, then read $8 back
    issue(32'h8c080000, 32'h44, 32'd0,  1'b1, 32'h0, 1'b0, 1'b0, 32'hdeadbeef);
    issue(32'h01004820, 32'h48, 32'hdeadbeef, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    // slt: $10 = -1, $11 = 1
    issue(32'h200affff, 32'h4c, 32'hffffffff, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h200b0001, 32'h50, 32'd1,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h014b602a, 32'h54, 32'd1,  1'b1, 32'd1, 1'b1, 1'b0, 32'h0);
    issue(32'h01806820, 32'h58, 32'd1,  1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    issue(32'h016a682a, 32'h5c, 32'd0,  1'b1, 32'hffffffff, 1'b1, 1'b0, 32'h0);
    // sub: 1 - (-1) = 2
    issue(32'h016a7022, 32'h60, 32'd2,  1'b1, 32'hffffffff, 1'b1, 1'b0, 32'h0);
    // write to $0 ignored
    issue(32'h20000005, 32'h64, 32'd5,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h00007820, 32'h68, 32'd0,  1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    // unknown funct: aluout 0, $4 keeps 7
    issue(32'h00e2203f, 32'h6c, 32'd0,  1'b1, 32'd5, 1'b1, 1'b0, 32'h0);
    issue(32'h00808820, 32'h70, 32'd7,  1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    // unknown opcode: no write, pc + 4
    issue(32'hfc000000, 32'h74, 32'd0,  1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h00000000, 32'h78, 32'd0,  1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    // read-during-write: addi $2,$2,1 sees old 5, then 6 is visible
    issue(32'h20420001, 32'h7c, 32'd6,  1'b1, 32'd5, 1'b1, 1'b0, 32'h0);
    issue(32'h00409020, 32'h80, 32'd6,  1'b1, 32'h0, 1'b1, 1'b0, 32'h0);

    // asynchronous reset mid-run: pc and $2 clear before the next edge
    @(posedge clk);
    #1;
    rst   = 1'b0;
    instr = 32'h00400020;
    begin
      exp_t e;
      e = '{id: vec_id[7:0], pc: 32'h0, alu: 32'h0, chk_alu: 1'b1, wd: 32'h0, chk_wd: 1'b1, mw: 1'b0};
      exp_q.push_back(e);
      vec_id++;
    end
    drive_done = 1'b1;

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_core.md
Name: mips_core

Overview:
- Single-cycle MIPS32 datapath and controller, without instruction or data memory.
- Fetches through an external instruction port addressed by `pc`. Accesses external data memory through the `aluout`, `writedata`, `readdata` and `memwrite` ports.
- Sits between the top-level instruction ROM and data RAM. Every instruction completes in one clock cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `instr` input 32: instruction word at address `pc`. Combinational from the instruction ROM.
- `pc` output 32: current program counter, the instruction fetch address.
- `memwrite` output 1: data-memory write enable. High only for sw.
- `aluout` output 32: ALU result. Serves as the data-memory address for lw/sw.
- `writedata` output 32: register file read port 2 (rt) value. This is the data stored by sw.
- `readdata` input 32: data-memory read data. Combinational, used by lw.

Behaviour:
- **Reset**
  - `rst`=0 asynchronously sets PC=RESET_PC and clears all 32 registers to 0. This holds for as long as `rst` stays low.
  - Outputs during reset are combinational from PC=0, zeroed registers and `instr`. `memwrite` follows the decode of `instr`.
- **Register file**
  - 32×32 bits; two combinational read ports (rs, rt); one write port written on the rising edge.
  - $0 always reads 0; writes to $0 are ignored.
  - Read-during-write returns the old value. The new value is visible in the next cycle.
- **Decode (opcode [31:26])**
  - 000000 R-type: reg write to rd [15:11]; ALU operands rs, rt.
  - 100011 lw: reg write to rt with `readdata`; ALU computes rs + signext(imm).
  - 101011 sw: `memwrite`=1; ALU computes rs + signext(imm); `writedata`=rt.
  - 000100 beq: ALU computes rs − rt; branch taken when the result is zero; no writes.
  - 001000 addi: rt ← rs + signext(imm).
  - 000010 j: PC ← {PC+4[31:28], instr[25:0], 2'b00}; no writes.
  - Any other opcode: no register write, `memwrite`=0, PC ← PC+4.
- **R-type funct [5:0]**
  - 100000 add, 100010 sub, 100100 and, 100101 or.
  - 101010 slt: signed compare, result 1 or 0.
  - Other funct: `aluout`=0 and no register write.
- **Arithmetic and width rules**
  - All arithmetic is 32-bit two's complement, wraps on overflow, and raises no exception.
  - The 16-bit immediate is sign-extended.
- **Next PC**
  - Default: PC+4.
  - beq taken: PC+4 + (signext(imm) << 2).
  - j: jump target as defined under Decode.
- **Timing**
  - Register and PC updates occur on the rising `clk` edge following a combinationally valid `instr`.
  - `aluout`, `writedata` and `memwrite` are purely combinational functions of `instr` and state.
- No delay slots, no hazards, and no stalls.

Test Plan:
- Reset: hold `rst`=0 and toggle `clk` → `pc` stays 0 and all registers stay 0. Release reset → `pc` advances by 4 per cycle with nop (32'h0) instructions.
- addi sequence from reset, one instruction per cycle:
  - 20020005 → `aluout`=5, $2=5.
  - 2003000c → `aluout`=12, $3=12.
  - 2067fff7 → `aluout`=3, $7=3 (negative immediate).
- Logic/add sequence, continuing:
  - 00e22025 (or) → `aluout`=7, $4=7.
  - 00642824 (and) → `aluout`=4, $5=4.
  - 00a42820 (add) → `aluout`=11, $5=11.
- beq not taken: 10a7000a with $5=11, $7=3 → `aluout`=8, `pc` += 4, `memwrite`=0.
- Taken branch and jump: beq with equal registers and imm=0x000a → `pc` = old+4+40. j 0x0000010 → `pc`=0x40.
- Memory and slt:
  - sw $7,4($0) → `memwrite`=1, `aluout`=4, `writedata`=3.
  - lw $8,0($0) with `readdata`=32'hdeadbeef → $8=deadbeef.
  - slt with −1 < 1 → result 1.
